// File: rtl/axis_gen_pkg.sv
// Shared types and helpers for the AXI4-Stream packet generator.
package axis_gen_pkg;

    localparam int unsigned AXIS_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } gen_state_t;

    // A zero-length request still produces a one-word packet.
    function automatic logic [15:0] eff_len(input logic [15:0] len);
        return (len == 16'd0) ? 16'd1 : len;
    endfunction

endpackage

// File: rtl/axis_pkt_gen_if.sv
// AXI4-Stream bus between the packet generator and its sink.
interface axis_pkt_gen_if
    import axis_gen_pkg::*;
#(
    parameter int unsigned DATA_W = AXIS_DATA_W
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: fixed-length packets, counting payload, programmable gap.
module axis_pkt_gen
    import axis_gen_pkg::*;
#(
    parameter int unsigned DATA_W = AXIS_DATA_W,
    parameter int unsigned GAP_W  = 8
) (
    input  logic                  clk_200,
    input  logic                  sys_arstn,
    input  logic                  start,
    input  logic                  stop,
    input  logic [15:0]           pkt_len,
    input  logic [15:0]           pkt_count,
    input  logic [GAP_W-1:0]      gap,
    axis_pkt_gen_if.master        m_axis,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           pkts_sent
);

    gen_state_t        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       count_q, count_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0]       seq_q, seq_d;
    logic [15:0]       widx_q, widx_d;
    logic              stop_pend_q, stop_pend_d;
    logic [31:0]       pkts_sent_q, pkts_sent_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              last_word;
    logic              run_end;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        seq_d       = seq_q;
        widx_d      = widx_q;
        stop_pend_d = stop_pend_q;
        pkts_sent_d = pkts_sent_q;
        done_d      = 1'b0;

        last_word = (widx_q == len_q - 16'd1);
        // A stop arriving with the final handshake counts as already pending.
        run_end   = ((count_q != 16'd0) && (pkts_sent_q + 32'd1 == {16'd0, count_q}))
                    || stop_pend_q || stop;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    len_d       = eff_len(pkt_len);
                    count_d     = pkt_count;
                    gap_d       = gap;
                    pkts_sent_d = '0;
                    seq_d       = '0;
                    widx_d      = '0;
                    stop_pend_d = 1'b0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (stop) stop_pend_d = 1'b1;
                if (tvalid_q && m_axis.tready) begin
                    if (last_word) begin
                        widx_d = '0;
                        seq_d  = seq_q + 16'd1;
                        if (pkts_sent_q != '1) pkts_sent_d = pkts_sent_q + 32'd1;
                        if (run_end) begin
                            state_d     = IDLE;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end else if (gap_q != '0) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        widx_d = widx_q + 16'd1;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed from next state so they can be registered without latency.
        tvalid_d = (state_d == SEND);
        tdata_d  = tvalid_d ? DATA_W'(seq_d + widx_d) : '0;
        tlast_d  = tvalid_d && (widx_d == len_d - 16'd1);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk_200 or negedge sys_arstn) begin
        if (!sys_arstn) begin
            state_q     <= IDLE;
            len_q       <= 16'd1;
            count_q     <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            seq_q       <= '0;
            widx_q      <= '0;
            stop_pend_q <= 1'b0;
            pkts_sent_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            seq_q       <= seq_d;
            widx_q      <= widx_d;
            stop_pend_q <= stop_pend_d;
            pkts_sent_q <= pkts_sent_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pkts_sent     = pkts_sent_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: expected words queued per run, monitor checks stream.
module tb_axis_pkt_gen;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic        clk_200;
    logic        sys_arstn;
    logic        start;
    logic        stop;
    logic [15:0] pkt_len;
    logic [15:0] pkt_count;
    logic [7:0]  gap;
    logic        busy;
    logic        done;
    logic [31:0] pkts_sent;

    axis_pkt_gen_if #(.DATA_W(16)) axis_bus ();

    axis_pkt_gen #(.DATA_W(16), .GAP_W(8)) dut (
        .clk_200   (clk_200),
        .sys_arstn (sys_arstn),
        .start     (start),
        .stop      (stop),
        .pkt_len   (pkt_len),
        .pkt_count (pkt_count),
        .gap       (gap),
        .m_axis    (axis_bus),
        .busy      (busy),
        .done      (done),
        .pkts_sent (pkts_sent)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   hs_cnt  = 0;
    int   exp_gap = 0;
    bit   rnd_rdy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        clk_200 = 1'b0;
        forever #5 clk_200 = ~clk_200;
    end

    initial begin
        axis_bus.tready = 1'b1;
        forever begin
            @(posedge clk_200);
            #1;
            axis_bus.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake, watches stalls, gaps and done timing.
    initial begin
        bit          prev_stall   = 0;
        bit          prev_hs_last = 0;
        bit          gap_arm      = 0;
        int          idle_cnt     = 0;
        logic [15:0] prev_data    = '0;
        logic        prev_last    = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk_200);
            if (!sys_arstn) begin
                prev_stall   = 0;
                prev_hs_last = 0;
                gap_arm      = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_tvalid", 32'(axis_bus.tvalid), 32'd1);
                    check("stall_tdata", 32'(axis_bus.tdata), 32'(prev_data));
                    check("stall_tlast", 32'(axis_bus.tlast), 32'(prev_last));
                end
                if (axis_bus.tvalid) begin
                    if (gap_arm) begin
                        check("gap_len", 32'(idle_cnt), 32'(exp_gap));
                        gap_arm = 0;
                    end
                    if (axis_bus.tready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_word", 32'(axis_bus.tdata), 32'hffff_ffff);
                        end else begin
                            e = exp_q.pop_front();
                            check("tdata", 32'(axis_bus.tdata), 32'(e.data));
                            check("tlast", 32'(axis_bus.tlast), 32'(e.last));
                        end
                        hs_cnt++;
                        if (axis_bus.tlast) begin
                            gap_arm  = 1;
                            idle_cnt = 0;
                        end
                    end
                end else if (gap_arm) begin
                    idle_cnt++;
                end
                if (!busy) gap_arm = 0;
                if (done) check("done_after_last", 32'(prev_hs_last), 32'd1);
                prev_hs_last = axis_bus.tvalid && axis_bus.tready && axis_bus.tlast;
                prev_stall   = axis_bus.tvalid && !axis_bus.tready;
                prev_data    = axis_bus.tdata;
                prev_last    = axis_bus.tlast;
            end
        end
    end

    task automatic push_run(input int len, input int pkts);
        int eff;
        eff = (len == 0) ? 1 : len;
        for (int p = 0; p < pkts; p++) begin
            for (int w = 0; w < eff; w++) begin
                exp_q.push_back('{data: 16'(p + w), last: (w == eff - 1)});
            end
        end
    endtask

    task automatic run_pkts(input int len, input int cnt, input int g, input bit rnd,
                            input int stop_at, input int exp_pkts);
        int k;
        bit got;
        push_run(len, exp_pkts);
        exp_gap = g;
        rnd_rdy = rnd;
        hs_cnt  = 0;
        @(posedge clk_200);
        #1;
        pkt_len   = 16'(len);
        pkt_count = 16'(cnt);
        gap       = 8'(g);
        start     = 1'b1;
        @(posedge clk_200);
        #1;
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_tvalid", 32'(axis_bus.tvalid), 32'd1);
        check("start_word0", 32'(axis_bus.tdata), 32'd0);
        // A second start with different settings while busy must change nothing.
        start     = 1'b1;
        pkt_len   = 16'(len + 1);
        pkt_count = 16'(cnt + 1);
        gap       = 8'(g + 1);
        @(posedge clk_200);
        #1;
        start = 1'b0;
        if (stop_at > 0) begin
            k = 0;
            while (hs_cnt < stop_at && k < 20000) begin
                @(posedge clk_200);
                #1;
                k++;
            end
            check("stop_reached", 32'(hs_cnt >= stop_at), 32'd1);
            stop = 1'b1;
            @(posedge clk_200);
            #1;
            stop = 1'b0;
        end
        got = 0;
        k   = 0;
        while (!got && k < 5000) begin
            @(negedge clk_200);
            if (done) got = 1;
            k++;
        end
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            check("done_busy", 32'(busy), 32'd0);
            check("pkts_sent", pkts_sent, 32'(exp_pkts));
            check("queue_drained", 32'(exp_q.size()), 32'd0);
            @(negedge clk_200);
            check("done_pulse", 32'(done), 32'd0);
        end
        exp_q.delete();
        rnd_rdy = 0;
    endtask

    initial begin
        int k;
        sys_arstn = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        pkt_len   = '0;
        pkt_count = '0;
        gap       = '0;
        #22;
        check("rst_tvalid", 32'(axis_bus.tvalid), 32'd0);
        check("rst_tlast", 32'(axis_bus.tlast), 32'd0);
        check("rst_tdata", 32'(axis_bus.tdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pkts", pkts_sent, 32'd0);
        @(negedge clk_200);
        sys_arstn = 1'b1;

        @(posedge clk_200);
        #1;
        pkt_len = 16'd4;
        pkt_count = 16'd1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk_200);
        #1;
        start = 1'b0;
        check("start_stop_ignored", 32'(busy), 32'd0);
        @(posedge clk_200);
        #1;
        stop = 1'b0;
        check("stop_idle_ignored", 32'(busy), 32'd0);

        run_pkts(4, 2, 0, 0, 0, 2);
        run_pkts(3, 2, 5, 0, 0, 2);
        run_pkts(8, 3, 2, 1, 0, 3);
        run_pkts(16, 0, 0, 0, 37, 3);
        run_pkts(0, 4, 0, 0, 0, 4);

        // Reset in the middle of a packet.
        push_run(8, 5);
        hs_cnt = 0;
        @(posedge clk_200);
        #1;
        pkt_len   = 16'd8;
        pkt_count = 16'd5;
        gap       = 8'd0;
        start     = 1'b1;
        @(posedge clk_200);
        #1;
        start = 1'b0;
        k = 0;
        while (hs_cnt < 11 && k < 1000) begin
            @(posedge clk_200);
            #1;
            k++;
        end
        check("reset_reach", 32'(hs_cnt >= 11), 32'd1);
        #2;
        sys_arstn = 1'b0;
        exp_q.delete();
        #1;
        check("arst_tvalid", 32'(axis_bus.tvalid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_tdata", 32'(axis_bus.tdata), 32'd0);
        check("arst_pkts", pkts_sent, 32'd0);
        @(negedge clk_200);
        @(negedge clk_200);
        sys_arstn = 1'b1;
        run_pkts(3, 2, 0, 0, 0, 2);

        for (int i = 0; i < 4; i++) begin
            int len;
            int cnt;
            int g;
            len = int'($urandom_range(2, 6));
            cnt = int'($urandom_range(2, 4));
            g   = int'($urandom_range(0, 3));
            run_pkts(len, cnt, g, 1, 0, cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
